// File: rtl/openddr_cmd_queue_if.sv
// Request/command bus of the DDR command queue.
// master = AXI-side controller plus scheduler/PHY environment, slave = the queue.
interface openddr_cmd_queue_if #(
   parameter int ADDR_WIDTH = 40,
   parameter int ID_WIDTH   = 12,
   parameter int DEPTH      = 8
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [ID_WIDTH-1:0]   req_id;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [7:0]            req_len;

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [2:0]            cmd_type;
   logic [2:0]            cmd_bank;
   logic [15:0]           cmd_row;
   logic [9:0]            cmd_col;
   logic [ID_WIDTH-1:0]   cmd_id;
   logic                  cmd_last;

   logic                  init_done;
   logic [CNT_W-1:0]      fifo_count;

   modport master (
      output req_valid, req_write, req_id, req_addr, req_len, cmd_ready, init_done,
      input  req_ready, cmd_valid, cmd_type, cmd_bank, cmd_row, cmd_col, cmd_id,
             cmd_last, fifo_count
   );

   modport slave (
      input  req_valid, req_write, req_id, req_addr, req_len, cmd_ready, init_done,
      output req_ready, cmd_valid, cmd_type, cmd_bank, cmd_row, cmd_col, cmd_id,
             cmd_last, fifo_count
   );
endinterface

// File: rtl/openddr_cmd_queue.sv
// In-order DDR command queue: buffers burst requests and turns the head
// request into PRE/ACT/RD/WR commands using a per-bank open-row table.
//
// state  | meaning
// IDLE   | load head entry, then decide row hit / miss / closed bank
// PRE    | precharge presented for head bank (row miss)
// ACT    | activate presented for head bank/row
// XFER   | RD or WR beats presented, column counting up, cmd_last on final beat
module openddr_cmd_queue #(
   parameter int ADDR_WIDTH = 40,
   parameter int ID_WIDTH   = 12,
   parameter int DEPTH      = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   openddr_cmd_queue_if.slave  bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [2:0] T_NOP = 3'd0;
   localparam logic [2:0] T_ACT = 3'd1;
   localparam logic [2:0] T_RD  = 3'd2;
   localparam logic [2:0] T_WR  = 3'd3;
   localparam logic [2:0] T_PRE = 3'd4;

   typedef enum logic [1:0] {S_IDLE, S_PRE, S_ACT, S_XFER} state_t;

   // request storage keeps only the mapped address fields
   logic                r_mem_wr   [DEPTH];
   logic [ID_WIDTH-1:0] r_mem_id   [DEPTH];
   logic [2:0]          r_mem_bank [DEPTH];
   logic [15:0]         r_mem_row  [DEPTH];
   logic [9:0]          r_mem_col  [DEPTH];
   logic [7:0]          r_mem_len  [DEPTH];

   logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0]    r_count;
   logic                r_live;

   state_t              r_state;
   logic                r_hd_ld;
   logic                r_hd_wr;
   logic [ID_WIDTH-1:0] r_hd_id;
   logic [2:0]          r_hd_bank;
   logic [15:0]         r_hd_row;
   logic [9:0]          r_hd_col;
   logic [7:0]          r_hd_len;
   logic [7:0]          r_beats;

   logic [7:0]          r_bank_open;
   logic [15:0]         r_bank_row [8];

   logic                r_cmd_valid;
   logic [2:0]          r_cmd_type;
   logic [2:0]          r_cmd_bank;
   logic [15:0]         r_cmd_row;
   logic [9:0]          r_cmd_col;
   logic [ID_WIDTH-1:0] r_cmd_id;
   logic                r_cmd_last;

   logic [ADDR_WIDTH-1:0] w_addr;
   logic                  w_unused_addr;
   logic                  w_push, w_pop;
   logic [2:0]            w_xfer_type;

   assign w_addr        = bus.req_addr;
   // only bits 31:3 carry the DRAM location; the rest are deliberately dropped
   assign w_unused_addr = ^w_addr;

   // r_live keeps req_ready low while reset is held
   assign bus.req_ready = r_live && (r_count < CNT_W'(DEPTH));
   assign w_push        = bus.req_valid && bus.req_ready;
   assign w_pop         = (r_state == S_XFER) && r_cmd_valid && bus.cmd_ready && r_cmd_last;
   assign w_xfer_type   = r_hd_wr ? T_WR : T_RD;

   assign bus.fifo_count = r_count;
   assign bus.cmd_valid  = r_cmd_valid;
   assign bus.cmd_type   = r_cmd_type;
   assign bus.cmd_bank   = r_cmd_bank;
   assign bus.cmd_row    = r_cmd_row;
   assign bus.cmd_col    = r_cmd_col;
   assign bus.cmd_id     = r_cmd_id;
   assign bus.cmd_last   = r_cmd_last;

   // FIFO pointers and occupancy; push and pop in one cycle cancel out
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_live   <= 1'b0;
      end else begin
         r_live <= 1'b1;
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
         else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
      end
   end

   // FIFO storage, address mapped on the way in
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_wr[r_wr_ptr]   <= bus.req_write;
         r_mem_id[r_wr_ptr]   <= bus.req_id;
         r_mem_bank[r_wr_ptr] <= w_addr[15:13];
         r_mem_row[r_wr_ptr]  <= w_addr[31:16];
         r_mem_col[r_wr_ptr]  <= w_addr[12:3];
         r_mem_len[r_wr_ptr]  <= bus.req_len;
      end
   end

   // issue FSM with registered command outputs and the open-row table
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_hd_ld     <= 1'b0;
         r_hd_wr     <= 1'b0;
         r_hd_id     <= '0;
         r_hd_bank   <= '0;
         r_hd_row    <= '0;
         r_hd_col    <= '0;
         r_hd_len    <= '0;
         r_beats     <= '0;
         r_bank_open <= '0;
         for (int i = 0; i < 8; i++) r_bank_row[i] <= '0;
         r_cmd_valid <= 1'b0;
         r_cmd_type  <= T_NOP;
         r_cmd_bank  <= '0;
         r_cmd_row   <= '0;
         r_cmd_col   <= '0;
         r_cmd_id    <= '0;
         r_cmd_last  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!r_hd_ld) begin
                  // registering the head first keeps the FIFO read off the decision path
                  if (r_count != '0) begin
                     r_hd_ld   <= 1'b1;
                     r_hd_wr   <= r_mem_wr[r_rd_ptr];
                     r_hd_id   <= r_mem_id[r_rd_ptr];
                     r_hd_bank <= r_mem_bank[r_rd_ptr];
                     r_hd_row  <= r_mem_row[r_rd_ptr];
                     r_hd_col  <= r_mem_col[r_rd_ptr];
                     r_hd_len  <= r_mem_len[r_rd_ptr];
                  end
               end else if (bus.init_done) begin
                  r_cmd_valid <= 1'b1;
                  r_cmd_bank  <= r_hd_bank;
                  r_cmd_row   <= r_hd_row;
                  r_cmd_col   <= r_hd_col;
                  r_cmd_id    <= r_hd_id;
                  r_beats     <= r_hd_len;
                  if (r_bank_open[r_hd_bank] && (r_bank_row[r_hd_bank] == r_hd_row)) begin
                     r_state    <= S_XFER;
                     r_cmd_type <= w_xfer_type;
                     r_cmd_last <= (r_hd_len == 8'd0);
                  end else if (r_bank_open[r_hd_bank]) begin
                     r_state    <= S_PRE;
                     r_cmd_type <= T_PRE;
                  end else begin
                     r_state    <= S_ACT;
                     r_cmd_type <= T_ACT;
                  end
               end
            end
            S_PRE: begin
               if (bus.cmd_ready) begin
                  r_bank_open[r_hd_bank] <= 1'b0;
                  r_state    <= S_ACT;
                  r_cmd_type <= T_ACT;
               end
            end
            S_ACT: begin
               if (bus.cmd_ready) begin
                  r_bank_open[r_hd_bank] <= 1'b1;
                  r_bank_row[r_hd_bank]  <= r_hd_row;
                  r_state    <= S_XFER;
                  r_cmd_type <= w_xfer_type;
                  r_cmd_last <= (r_hd_len == 8'd0);
               end
            end
            S_XFER: begin
               if (bus.cmd_ready) begin
                  if (r_cmd_last) begin
                     r_state     <= S_IDLE;
                     r_hd_ld     <= 1'b0;
                     r_cmd_valid <= 1'b0;
                     r_cmd_type  <= T_NOP;
                     r_cmd_bank  <= '0;
                     r_cmd_row   <= '0;
                     r_cmd_col   <= '0;
                     r_cmd_id    <= '0;
                     r_cmd_last  <= 1'b0;
                  end else begin
                     // column wraps 1023 -> 0 inside the same row
                     r_cmd_col  <= r_cmd_col + 10'd1;
                     r_beats    <= r_beats - 8'd1;
                     r_cmd_last <= (r_beats == 8'd1);
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_openddr_cmd_queue.sv
// Bench for openddr_cmd_queue: directed scenarios plus a random stream, all
// command streams checked against a request-level reference model.
module tb_openddr_cmd_queue;
   typedef logic [44:0] cmd_t;  // {type, bank, row, col, id, last}

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   ready_mode = 1;  // 0: hold off, 1: always ready, 2: random
   cmd_t exp_q[$];
   cmd_t obs_q[$];
   bit          m_open [8];
   logic [15:0] m_row  [8];

   openddr_cmd_queue_if #(.ADDR_WIDTH(40), .ID_WIDTH(12), .DEPTH(8)) bus ();

   openddr_cmd_queue #(.ADDR_WIDTH(40), .ID_WIDTH(12), .DEPTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // fields the command does not define for PRE/ACT are masked out
   function automatic cmd_t pk(input logic [2:0] t, input logic [2:0] b, input logic [15:0] r,
                               input logic [9:0] c, input logic [11:0] id, input logic last);
      logic [15:0] rr = r;
      logic [9:0]  cc = c;
      if (t == 3'd4) begin rr = '0; cc = '0; end
      if (t == 3'd1) cc = '0;
      return {t, b, rr, cc, id, last};
   endfunction

   // expected commands for one request, given the model's open-row table
   function automatic void model_push(input bit w, input logic [11:0] id, input logic [39:0] a, input int len);
      logic [2:0]  b = a[15:13];
      logic [15:0] r = a[31:16];
      logic [9:0]  c = a[12:3];
      if (!(m_open[b] && m_row[b] == r)) begin
         if (m_open[b]) exp_q.push_back(pk(3'd4, b, r, c, id, 1'b0));
         exp_q.push_back(pk(3'd1, b, r, c, id, 1'b0));
         m_open[b] = 1'b1;
         m_row[b]  = r;
      end
      for (int k = 0; k <= len; k++)
         exp_q.push_back(pk(w ? 3'd3 : 3'd2, b, r, 10'(int'(c) + k), id, k == len));
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 8; i++) m_open[i] = 1'b0;
      exp_q.delete();
   endfunction

   // drives cmd_ready and records handshakes seen by the next rising edge
   always @(negedge clk) begin
      case (ready_mode)
         0:       bus.cmd_ready = 1'b0;
         1:       bus.cmd_ready = 1'b1;
         default: bus.cmd_ready = 1'($urandom_range(0, 1));
      endcase
      if (rst_n && bus.cmd_valid && bus.cmd_ready)
         obs_q.push_back(pk(bus.cmd_type, bus.cmd_bank, bus.cmd_row, bus.cmd_col, bus.cmd_id, bus.cmd_last));
   end

   function automatic logic [39:0] mk_addr(input logic [15:0] row, input logic [2:0] bank, input logic [9:0] col);
      return {8'($urandom), row, bank, col, 3'($urandom)};
   endfunction

   // call at a falling edge; returns at the falling edge after the push edge
   task automatic push_req(input bit w, input logic [11:0] id, input logic [39:0] a, input logic [7:0] len);
      int n = 0;
      bus.req_valid = 1'b1;
      bus.req_write = w;
      bus.req_id    = id;
      bus.req_addr  = a;
      bus.req_len   = len;
      while (!bus.req_ready && n < 500) begin @(negedge clk); n++; end
      if (n >= 500) begin
         checks++; errors++;
         $display("FAIL push_timeout: req_ready stayed %b, want 1", bus.req_ready);
      end else begin
         model_push(w, id, a, int'(len));
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((obs_q.size() < exp_q.size() || bus.fifo_count != 4'd0 || bus.cmd_valid) && n < budget) begin
         @(negedge clk); n++;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_id = '0; bus.req_addr = '0; bus.req_len = '0;
      bus.init_done = 1'b1;
      ready_mode = 1;
      model_reset();
      repeat (3) @(negedge clk);
      checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", bus.req_ready); end
      checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid: got %b want 0", bus.cmd_valid); end
      checks++; if (bus.cmd_type !== 3'd0) begin errors++; $display("FAIL reset_cmd_type: got %0d want 0", bus.cmd_type); end
      checks++; if (bus.fifo_count !== 4'd0) begin errors++; $display("FAIL reset_fifo_count: got %0d want 0", bus.fifo_count); end
      checks++;
      if ({bus.cmd_bank, bus.cmd_row, bus.cmd_col, bus.cmd_id, bus.cmd_last} !== '0) begin
         errors++; $display("FAIL reset_cmd_fields: got %h want 0", {bus.cmd_bank, bus.cmd_row, bus.cmd_col, bus.cmd_id, bus.cmd_last});
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_req_ready: got %b want 1", bus.req_ready); end
      obs_q.delete();
   endtask

   task automatic test_closed_bank();
      push_req(1'b0, 12'h0A1, 40'h00_0001_2008, 8'd1);
      checks++; if (bus.fifo_count !== 4'd1) begin errors++; $display("FAIL closed_count_push: got %0d want 1", bus.fifo_count); end
      wait_drain(50);
      checks++; if (bus.fifo_count !== 4'd0) begin errors++; $display("FAIL closed_count_drain: got %0d want 0", bus.fifo_count); end
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL closed_len: got %0d cmds want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL closed_cmd%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_row_hit();
      push_req(1'b0, 12'h0B2, 40'h00_0001_2028, 8'd0);
      @(negedge clk);
      checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL hit_latency_1: cmd_valid got %b want 0", bus.cmd_valid); end
      @(negedge clk);
      checks++; if (bus.cmd_valid !== 1'b1) begin errors++; $display("FAIL hit_latency_2: cmd_valid got %b want 1", bus.cmd_valid); end
      checks++;
      if (bus.cmd_type !== 3'd2 || bus.cmd_col !== 10'd5) begin
         errors++; $display("FAIL hit_first_cmd: got type %0d col %0d want type 2 col 5", bus.cmd_type, bus.cmd_col);
      end
      wait_drain(50);
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL hit_len: got %0d cmds want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL hit_cmd%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_row_miss();
      push_req(1'b1, 12'h0C3, 40'h00_0002_2000, 8'd0);
      push_req(1'b1, 12'h0C4, 40'h00_0002_2010, 8'd0);
      wait_drain(60);
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL miss_len: got %0d cmds want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL miss_cmd%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_full();
      logic [45:0] snap;
      logic [39:0] a9;
      ready_mode = 0;
      @(negedge clk);
      for (int i = 0; i < 8; i++)
         push_req(1'($urandom), 12'(16 + i), mk_addr(16'($urandom_range(0, 2)), 3'($urandom_range(0, 3)), 10'($urandom)),
                  8'($urandom_range(0, 3)));
      checks++; if (bus.fifo_count !== 4'd8) begin errors++; $display("FAIL full_count: got %0d want 8", bus.fifo_count); end
      checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL full_req_ready: got %b want 0", bus.req_ready); end
      a9 = mk_addr(16'h0003, 3'd6, 10'd100);
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_id = 12'h0FF; bus.req_addr = a9; bus.req_len = 8'd1;
      snap = {bus.cmd_valid, bus.cmd_type, bus.cmd_bank, bus.cmd_row, bus.cmd_col, bus.cmd_id, bus.cmd_last};
      repeat (5) @(negedge clk);
      bus.req_valid = 1'b0;
      checks++; if (bus.fifo_count !== 4'd8) begin errors++; $display("FAIL full_no_overflow: got %0d want 8", bus.fifo_count); end
      checks++; if (snap[45] !== 1'b1) begin errors++; $display("FAIL full_head_valid: got %b want 1", snap[45]); end
      checks++;
      if ({bus.cmd_valid, bus.cmd_type, bus.cmd_bank, bus.cmd_row, bus.cmd_col, bus.cmd_id, bus.cmd_last} !== snap) begin
         errors++; $display("FAIL full_stable: got %h want %h",
                            {bus.cmd_valid, bus.cmd_type, bus.cmd_bank, bus.cmd_row, bus.cmd_col, bus.cmd_id, bus.cmd_last}, snap);
      end
      ready_mode = 1;
      push_req(1'b0, 12'h0FF, a9, 8'd1);
      wait_drain(300);
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL full_len: got %0d cmds want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL full_cmd%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_col_wrap();
      push_req(1'b1, 12'h0D5, mk_addr(16'h0005, 3'd2, 10'd1023), 8'd2);
      wait_drain(60);
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL wrap_len: got %0d cmds want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL wrap_cmd%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_reset_mid_xfer();
      int n = 0;
      push_req(1'b0, 12'h0E6, mk_addr(16'h0007, 3'd3, 10'd0), 8'd20);
      while (!(bus.cmd_valid && bus.cmd_type == 3'd2) && n < 50) begin @(negedge clk); n++; end
      checks++; if (n >= 50) begin errors++; $display("FAIL rst_reach_xfer: cmd_type got %0d want 2", bus.cmd_type); end
      rst_n = 1'b0;
      #1;
      checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", bus.cmd_valid); end
      checks++; if (bus.cmd_type !== 3'd0) begin errors++; $display("FAIL rst_mid_type: got %0d want 0", bus.cmd_type); end
      checks++; if (bus.fifo_count !== 4'd0) begin errors++; $display("FAIL rst_mid_count: got %0d want 0", bus.fifo_count); end
      checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %b want 0", bus.req_ready); end
      checks++;
      if ({bus.cmd_bank, bus.cmd_row, bus.cmd_col, bus.cmd_id, bus.cmd_last} !== '0) begin
         errors++; $display("FAIL rst_mid_fields: got %h want 0", {bus.cmd_bank, bus.cmd_row, bus.cmd_col, bus.cmd_id, bus.cmd_last});
      end
      bus.init_done = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      obs_q.delete();
   endtask

   task automatic test_init_gating();
      int n = 0;
      int n1;
      push_req(1'b0, 12'h0F7, mk_addr(16'h0007, 3'd3, 10'd4), 8'd0);
      repeat (10) @(negedge clk);
      checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL gate_valid: got %b want 0", bus.cmd_valid); end
      checks++; if (bus.fifo_count !== 4'd1) begin errors++; $display("FAIL gate_count: got %0d want 1", bus.fifo_count); end
      bus.init_done = 1'b1;
      wait_drain(50);
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL gate_len: got %0d cmds want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL gate_cmd%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
         end
      end
      exp_q.delete(); obs_q.delete();
      // init_done dropping mid-burst lets the burst finish but holds the next one
      push_req(1'b0, 12'h101, mk_addr(16'h0001, 3'd4, 10'd0), 8'd15);
      n1 = exp_q.size();
      push_req(1'b1, 12'h102, mk_addr(16'h0003, 3'd5, 10'd8), 8'd0);
      while (!(bus.cmd_valid && bus.cmd_type == 3'd2 && bus.cmd_id == 12'h101) && n < 60) begin @(negedge clk); n++; end
      bus.init_done = 1'b0;
      repeat (40) @(negedge clk);
      checks++; if (obs_q.size() != n1) begin errors++; $display("FAIL middrop_len: got %0d cmds want %0d", obs_q.size(), n1); end
      checks++; if (bus.fifo_count !== 4'd1) begin errors++; $display("FAIL middrop_count: got %0d want 1", bus.fifo_count); end
      checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL middrop_valid: got %b want 0", bus.cmd_valid); end
      bus.init_done = 1'b1;
      wait_drain(60);
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL middrop_total: got %0d cmds want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL middrop_cmd%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_random();
      ready_mode = 2;
      for (int i = 0; i < 40; i++) begin
         push_req(1'($urandom), 12'($urandom), mk_addr(16'($urandom_range(0, 2)), 3'($urandom_range(0, 3)), 10'($urandom)),
                  8'($urandom_range(0, 3)));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_drain(2000);
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_len: got %0d cmds want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL rand_cmd%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
         end
      end
      exp_q.delete(); obs_q.delete();
      ready_mode = 1;
   endtask

   initial begin
      test_reset();
      test_closed_bank();
      test_row_hit();
      test_row_miss();
      test_full();
      test_col_wrap();
      test_reset_mid_xfer();
      test_init_gating();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/openddr_cmd_queue.md
OPENDDR_CMD_QUEUE -- requirements
Module: openddr_cmd_queue

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 40, byte address width of requests.
REQ-002 SHALL have parameter ID_WIDTH, default 12, transaction ID width.
REQ-003 SHALL have parameter DEPTH, default 8, request FIFO entries (power of 2, >=2).
REQ-004 SHALL have port clk  in  1  single clock, all logic rising-edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports req_valid in 1, req_ready out 1: burst request handshake from the AXI controller.
REQ-007 SHALL have ports req_write in 1 (1=write, 0=read), req_id in ID_WIDTH, req_addr in ADDR_WIDTH, req_len in 8 (beats-1).
REQ-008 SHALL have ports cmd_valid out 1, cmd_ready in 1: DDR command handshake to the scheduler/PHY.
REQ-009 SHALL have port cmd_type out 3: 0=NOP, 1=ACT, 2=RD, 3=WR, 4=PRE.
REQ-010 SHALL have ports cmd_bank out 3, cmd_row out 16, cmd_col out 10, cmd_id out ID_WIDTH, cmd_last out 1 (final beat of burst).
REQ-011 SHALL have port init_done in 1: DRAM initialisation complete; no command issued while low.
REQ-012 SHALL have port fifo_count out $clog2(DEPTH)+1: occupied entries.

Function
REQ-013 SHALL map addresses: col=req_addr[12:3], bank=req_addr[15:13], row=req_addr[31:16]; higher bits ignored.
REQ-014 SHALL assert req_ready = (fifo_count < DEPTH); no same-cycle bypass when full.
REQ-015 SHALL push on req_valid&&req_ready, pop head on handshake of its cmd_last beat; simultaneous push+pop leaves fifo_count unchanged.
REQ-016 SHALL keep a per-bank open-row table (8 x {open, row[15:0]}), updated on ACT handshake (open=1,row) and PRE handshake (open=0).
REQ-017 SHALL run issue FSM states IDLE, PRE, ACT, XFER.
REQ-018 IDLE SHALL go to XFER if head bank open with same row, PRE if open with different row, ACT if closed; only when fifo_count>0 and init_done=1.
REQ-019 PRE SHALL present cmd_type=PRE for head bank and go to ACT on handshake.
REQ-020 ACT SHALL present cmd_type=ACT with head bank/row and go to XFER on handshake.
REQ-021 XFER SHALL present req_len+1 RD or WR commands, cmd_col starting at mapped col and incrementing by 1 per handshake, wrapping 1023->0 within the row.
REQ-022 cmd_last SHALL be 1 only on the (req_len+1)th beat; on its handshake the FSM returns to IDLE.
REQ-023 cmd_valid SHALL be 1 only in PRE/ACT/XFER; cmd_type=NOP when cmd_valid=0.
REQ-024 All cmd_* outputs SHALL remain stable while cmd_valid=1 and cmd_ready=0.
REQ-025 cmd_id SHALL equal head req_id on every command of that burst.
REQ-026 Minimum latency: request into empty FIFO hitting an open row SHALL produce cmd_valid 2 cycles after the push edge (push cycle +1 register, +1 FSM decision).
REQ-027 init_done falling mid-burst SHALL NOT abort; the current burst completes, new bursts wait.
REQ-028 Requests SHALL be issued strictly in arrival order; no reordering.

Reset
REQ-029 While rst_n=0: FIFO empty, fifo_count=0, req_ready=0 during reset then 1, FSM=IDLE, cmd_valid=0, cmd_type=NOP, cmd_bank/row/col/id=0, cmd_last=0, all banks closed.
REQ-030 Reset asserted mid-burst SHALL discard all queued requests and the bank table immediately.

Verification
REQ-031 Closed bank: init_done=1, read addr 0x0001_2008 len 1 -> ACT bank 1 row 0x0001, then RD col 1, RD col 2 (cmd_last=1), fifo_count 1->0.
REQ-032 Row hit: second read to bank 1 row 0x0001 col 5 len 0 -> single RD col 5, no ACT/PRE, first cmd_valid 2 cycles after push.
REQ-033 Row miss: write bank 1 row 0x0002 -> PRE bank 1, ACT row 0x0002, WR; table shows row 0x0002 open.
REQ-034 Backpressure/full: cmd_ready=0, push 9 requests -> req_ready=0 after 8, fifo_count=8, cmd_* stable; release -> drains in order.
REQ-035 Column wrap: col 1023 len 2 -> WR cols 1023, 0, 1 with cmd_last on col 1.
REQ-036 Reset mid-XFER and init_done=0 gating -> outputs at reset values; no command until init_done=1.
